// File: rtl/rvfi_reorder_pkg.sv
// Shared types for the RVFI reorder buffer: the stored retirement entry
// and the modular window-distance helper.
package rvfi_reorder_pkg;

    localparam int unsigned XLEN_MAX  = 64;
    localparam int unsigned ORDER_MAX = 64;

    typedef struct packed {
        logic [31:0]           insn;
        logic                  trap;
        logic [XLEN_MAX-1:0]   pc_rdata;
        logic [XLEN_MAX-1:0]   pc_wdata;
        logic [ORDER_MAX-1:0]  order;
    } rvfi_entry_t;

    // Low ORDER_W bits of the result equal the ORDER_W-wide modular distance
    function automatic logic [ORDER_MAX-1:0] win_dist(
        input logic [ORDER_MAX-1:0] ord,
        input logic [ORDER_MAX-1:0] nxt
    );
        return ord - nxt;
    endfunction

endpackage

// File: rtl/rvfi_reorder_mem.sv
// Slot storage for the reorder buffer: DEPTH entries with occupied bits,
// one write port, one read port and one clear port.
module rvfi_reorder_mem
    import rvfi_reorder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  rvfi_entry_t       wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output rvfi_entry_t       rdata_o,
    input  logic              clr_i,
    input  logic [AW-1:0]     caddr_i,
    output logic [DEPTH-1:0]  occ_o
);

    rvfi_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0]  occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (clr_i) occ_d[caddr_i] = 1'b0;
        if (we_i)  occ_d[waddr_i] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    // Payload is never reset; only the occupied bits qualify it
    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
    assign occ_o   = occ_q;

endmodule

// File: rtl/rvfi_reorder_buf.sv
// Reorders out-of-order RVFI retirements into sequence-number order.
// Define RISCV_FORMAL_REORDER_BYPASS_EN for a 0-latency in-order bypass.
module rvfi_reorder_buf
    import rvfi_reorder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ORDER_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [ORDER_W-1:0] in_order,
    input  logic [31:0]        in_insn,
    input  logic               in_trap,
    input  logic [XLEN-1:0]    in_pc_rdata,
    input  logic [XLEN-1:0]    in_pc_wdata,
    output logic               out_valid,
    output logic [ORDER_W-1:0] out_order,
    output logic [31:0]        out_insn,
    output logic               out_trap,
    output logic [XLEN-1:0]    out_pc_rdata,
    output logic [XLEN-1:0]    out_pc_wdata,
    output logic               error
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [ORDER_W-1:0]   next_q, next_d;
    logic                 err_q, err_d;
    logic [DEPTH-1:0]     occ;
    rvfi_entry_t          wr, rd, sel;
    logic [ORDER_MAX-1:0] dist_full;
    logic [IW-1:0]        wslot, rslot;
    logic                 in_win, accept, rel, bypass, wr_en;
    logic                 unused_bits;

    assign wr.insn     = in_insn;
    assign wr.trap     = in_trap;
    assign wr.pc_rdata = XLEN_MAX'(in_pc_rdata);
    assign wr.pc_wdata = XLEN_MAX'(in_pc_wdata);
    assign wr.order    = ORDER_MAX'(in_order);

    assign dist_full = win_dist(ORDER_MAX'(in_order), ORDER_MAX'(next_q));
    assign in_win    = dist_full[ORDER_W-1:0] < ORDER_W'(DEPTH);
    assign wslot     = in_order[IW-1:0];
    assign rslot     = next_q[IW-1:0];
    // An occupied target slot covers both duplicates and the full buffer
    assign accept    = in_valid && in_win && !occ[wslot];
    assign rel       = occ[rslot];

`ifdef RISCV_FORMAL_REORDER_BYPASS_EN
    assign bypass = in_valid && (in_order == next_q) && !occ[rslot];
    assign sel    = bypass ? wr : rd;
`else
    assign bypass = 1'b0;
    assign sel    = rd;
`endif

    assign wr_en = accept && !bypass;

    rvfi_reorder_mem #(
        .DEPTH (DEPTH),
        .AW    (IW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .we_i    (wr_en),
        .waddr_i (wslot),
        .wdata_i (wr),
        .raddr_i (rslot),
        .rdata_o (rd),
        .clr_i   (rel),
        .caddr_i (rslot),
        .occ_o   (occ)
    );

    assign out_valid    = rel | bypass;
    assign out_order    = sel.order[ORDER_W-1:0];
    assign out_insn     = sel.insn;
    assign out_trap     = sel.trap;
    assign out_pc_rdata = sel.pc_rdata[XLEN-1:0];
    assign out_pc_wdata = sel.pc_wdata[XLEN-1:0];

    assign next_d = out_valid ? next_q + 1'b1 : next_q;
    assign err_d  = err_q | (in_valid & ~accept);

    always_ff @(posedge clock) begin
        if (reset) begin
            next_q <= '0;
            err_q  <= 1'b0;
        end else begin
            next_q <= next_d;
            err_q  <= err_d;
        end
    end

    assign error = err_q;

    assign unused_bits = ^{dist_full, sel.pc_rdata, sel.pc_wdata, sel.order};

endmodule

// File: tb/tb_rvfi_reorder_buf.sv
// Directed scoreboard bench for rvfi_reorder_buf (DEPTH=4, ORDER_W=8).
module tb_rvfi_reorder_buf;

    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int ORDER_W = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [ORDER_W-1:0] in_order;
    logic [31:0]        in_insn;
    logic               in_trap;
    logic [XLEN-1:0]    in_pc_rdata;
    logic [XLEN-1:0]    in_pc_wdata;
    logic               out_valid;
    logic [ORDER_W-1:0] out_order;
    logic [31:0]        out_insn;
    logic               out_trap;
    logic [XLEN-1:0]    out_pc_rdata;
    logic [XLEN-1:0]    out_pc_wdata;
    logic               error;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    rvfi_reorder_buf #(
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .ORDER_W (ORDER_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_order     (in_order),
        .in_insn      (in_insn),
        .in_trap      (in_trap),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .out_valid    (out_valid),
        .out_order    (out_order),
        .out_insn     (out_insn),
        .out_trap     (out_trap),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Payload derived from the order number: insn, trap, pc_rdata, pc_wdata
    function automatic logic [96:0] fld(input int o);
        logic [7:0]  b;
        logic [31:0] pr;
        b  = o[7:0];
        pr = 32'h1000 + 32'(b) * 4;
        return {24'hC0FFEE, b, b[0], pr, pr + 32'd4};
    endfunction

    task automatic check_out(input int ov);
        logic [104:0] obs, exp_v;
        int o;
        if (ov != 2) begin
            vectors++;
            assert (out_valid === ov[0]) else begin
                miscompares++;
                $error("FAIL out_valid got %b want %0d", out_valid, ov);
            end
        end
        if (out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_out got order %0d want none", out_order);
            end else begin
                o     = exp_q.pop_front();
                obs   = {out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata};
                exp_v = {o[7:0], fld(o)};
                assert (obs === exp_v) else begin
                    miscompares++;
                    $error("FAIL out_fields got %h want %h", obs, exp_v);
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input int ord, input int ov, input bit rst = 1'b0);
        logic [96:0] f;
        @(negedge clock);
        check_out(ov);
        f           = fld(ord);
        reset       = rst;
        in_valid    = v;
        in_order    = ord[7:0];
        in_insn     = f[96:65];
        in_trap     = f[64];
        in_pc_rdata = f[63:32];
        in_pc_wdata = f[31:0];
    endtask

    task automatic chk_err(input bit e, input string tag);
        vectors++;
        assert (error === e) else begin
            miscompares++;
            $error("FAIL %s error got %b want %b", tag, error, e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc(1'b0, 0, 2);
            n++;
        end
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL drain got %0d pending want 0", exp_q.size());
        end
        cyc(1'b0, 0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_order = '0;
        in_insn  = '0;
        in_trap  = 1'b0;
        in_pc_rdata = '0;
        in_pc_wdata = '0;
        cyc(1'b0, 0, 2, 1'b1);
        cyc(1'b0, 0, 2, 1'b1);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "reset");

        // In-order 0,1,2: outputs one cycle later
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        cyc(1'b1, 0, 0);
        cyc(1'b1, 1, 1);
        cyc(1'b1, 2, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "inorder");

        // Out-of-order 5,3,4 with next_order=3
        exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
        cyc(1'b1, 5, 0);
        cyc(1'b1, 3, 0);
        cyc(1'b1, 4, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "reorder");

        // Hole at 6, 10 is outside the window and dropped
        exp_q.push_back(6); exp_q.push_back(7);
        exp_q.push_back(8); exp_q.push_back(9);
        cyc(1'b1, 7, 0);
        cyc(1'b1, 8, 0);
        cyc(1'b1, 9, 0);
        cyc(1'b1, 10, 0);
        chk_err(1'b0, "window_pre");
        cyc(1'b1, 6, 0);
        chk_err(1'b1, "window_drop");
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 0);
        chk_err(1'b1, "sticky");

        // Reset with in_valid high must ignore the input and clear error
        cyc(1'b1, 0, 2, 1'b1);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "reset2");
        cyc(1'b0, 0, 0);

        // Duplicate order 5 while next_order=3
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        cyc(1'b1, 0, 0);
        cyc(1'b1, 1, 1);
        cyc(1'b1, 2, 1);
        exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
        cyc(1'b1, 5, 1);
        cyc(1'b1, 5, 0);
        cyc(1'b1, 3, 0);
        chk_err(1'b1, "dup");
        cyc(1'b1, 4, 1);
        drain();

        // Mid-operation reset discards buffered 1,2
        cyc(1'b1, 0, 2, 1'b1);
        cyc(1'b1, 1, 0);
        cyc(1'b1, 2, 0);
        cyc(1'b1, 0, 0, 1'b1);
        cyc(1'b0, 0, 0);
        cyc(1'b0, 0, 0);
        exp_q.push_back(0);
        cyc(1'b1, 0, 0);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 0);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "reset_mid");

        // Walk next_order to 255, then wrap through 0 to 1 and 2
        for (int i = 1; i <= 255; i++) begin
            exp_q.push_back(i);
            cyc(1'b1, i, (i == 1) ? 0 : 1);
        end
        exp_q.push_back(0);
        cyc(1'b1, 0, 1);
        exp_q.push_back(1);
        cyc(1'b1, 1, 1);
        exp_q.push_back(2);
        cyc(1'b1, 2, 1);
        cyc(1'b0, 0, 1);
        cyc(1'b0, 0, 0);
        chk_err(1'b0, "wrap");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
